// File: rtl/imm_decode_stage_if.sv
// Handshake bundle between fetch and the immediate-decode stage.
// Carries the upstream instruction beat and the decoded downstream beat.
// master drives instructions and out_ready; slave is the decode stage.
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_insn;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_jimm;
    logic [XLEN-1:0] out_target;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_insn, out_pc, out_imm, out_jimm,
               out_target, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_insn, out_pc, out_imm, out_jimm,
               out_target, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate-generation stage: decodes RV32I/RV64I immediates, branch/JAL targets, illegal flag.
// Latency 1 cycle from input handshake to out_valid.
// SKID=1: 2-entry skid, in_ready = !skid_full (registered); SKID=0: in_ready = !out_valid | out_ready.
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_decode_stage_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    localparam logic [XLEN-1:0] LINK_INC = XLEN'(4);

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] jimm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t dec;
    entry_t out_ent_q, out_ent_d;
    entry_t skd_ent_q, skd_ent_d;
    logic   out_vld_q, out_vld_d;
    logic   skd_vld_q, skd_vld_d;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            is_shift;
    logic [11:0]     s_raw;
    logic [12:0]     b_raw;
    logic [20:0]     j_raw;
    logic [31:0]     u_raw;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] off_b;
    logic [XLEN-1:0] off_j;
    logic            accept;
    logic            in_rdy;

    // Immediate field extraction, sign extension via signed size casts
    always_comb begin
        opc      = bus.in_insn[6:0];
        f3       = bus.in_insn[14:12];
        is_shift = (f3 == 3'd1) || (f3 == 3'd5);
        s_raw    = {bus.in_insn[31:25], bus.in_insn[11:7]};
        b_raw    = {bus.in_insn[31], bus.in_insn[7], bus.in_insn[30:25], bus.in_insn[11:8], 1'b0};
        j_raw    = {bus.in_insn[31], bus.in_insn[19:12], bus.in_insn[20], bus.in_insn[30:21], 1'b0};
        u_raw    = {bus.in_insn[31:12], 12'b0};
        imm_i    = XLEN'($signed(bus.in_insn[31:20]));
        imm_s    = XLEN'($signed(s_raw));
        imm_u    = XLEN'($signed(u_raw));
        off_b    = XLEN'($signed(b_raw));
        off_j    = XLEN'($signed(j_raw));
    end

    // Decode the incoming instruction into a complete entry; illegal encodings zero all results
    always_comb begin
        dec         = '0;
        dec.insn    = bus.in_insn;
        dec.pc      = bus.in_pc;
        case (opc)
            7'h13: begin
                dec.fmt = FMT_I;
                if (is_shift) begin
                    if (XLEN == 32) begin
                        dec.imm     = XLEN'(bus.in_insn[24:20]);
                        dec.illegal = bus.in_insn[25];
                    end else begin
                        dec.imm = XLEN'(bus.in_insn[25:20]);
                    end
                end else begin
                    dec.imm = imm_i;
                end
            end
            7'h1B: begin
                if (XLEN == 32) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = is_shift ? XLEN'(bus.in_insn[24:20]) : imm_i;
                end
            end
            7'h03: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            7'h23: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
            end
            7'h37, 7'h17: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            7'h6F: begin
                dec.fmt    = FMT_J;
                dec.imm    = LINK_INC;
                dec.jimm   = off_j;
                dec.target = bus.in_pc + off_j;
            end
            7'h67: begin
                // target needs rs1, so it is left for execute
                dec.fmt  = FMT_I;
                dec.imm  = LINK_INC;
                dec.jimm = imm_i;
            end
            7'h63: begin
                dec.fmt    = FMT_B;
                dec.jimm   = off_b;
                dec.target = bus.in_pc + off_b;
            end
            7'h33, 7'h0F, 7'h73: begin
                dec.fmt = FMT_NONE;
            end
            7'h3B: begin
                dec.illegal = (XLEN == 32);
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (bus.in_insn[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end
        if (dec.illegal) begin
            dec.imm    = '0;
            dec.jimm   = '0;
            dec.target = '0;
            dec.fmt    = FMT_NONE;
        end
    end

    // Ready is a direct flop output in skid mode; forced low while reset is held
    always_comb begin
        if (SKID != 0) begin
            in_rdy = !rst && !skd_vld_q;
        end else begin
            in_rdy = !rst && (!out_vld_q || bus.out_ready);
        end
        accept = bus.in_valid && in_rdy;
    end

    // Next-state for the output and skid entries: reset, then flush, then normal flow
    always_comb begin
        out_vld_d = out_vld_q;
        out_ent_d = out_ent_q;
        skd_vld_d = skd_vld_q;
        skd_ent_d = skd_ent_q;
        if (rst) begin
            out_vld_d = 1'b0;
            out_ent_d = '0;
            skd_vld_d = 1'b0;
            skd_ent_d = '0;
        end else if (flush) begin
            out_vld_d = 1'b0;
            skd_vld_d = 1'b0;
        end else if (SKID != 0 && skd_vld_q) begin
            // skid full implies OUT full and in_ready low; only a drain can happen
            if (bus.out_ready) begin
                out_ent_d = skd_ent_q;
                skd_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_vld_q || bus.out_ready) begin
                out_ent_d = dec;
                out_vld_d = 1'b1;
            end else begin
                skd_ent_d = dec;
                skd_vld_d = 1'b1;
            end
        end else if (out_vld_q && bus.out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        out_vld_q <= out_vld_d;
        out_ent_q <= out_ent_d;
        skd_vld_q <= skd_vld_d;
        skd_ent_q <= skd_ent_d;
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_insn    = out_ent_q.insn;
    assign bus.out_pc      = out_ent_q.pc;
    assign bus.out_imm     = out_ent_q.imm;
    assign bus.out_jimm    = out_ent_q.jimm;
    assign bus.out_target  = out_ent_q.target;
    assign bus.out_fmt     = out_ent_q.fmt;
    assign bus.out_illegal = out_ent_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep.
// Outputs sampled 1 time unit after the rising edge.
// Covers decode vectors, skid hold/drain ordering, flush and mid-stall reset.
module tb_imm_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) if32 ();
    imm_decode_stage_if #(.XLEN(64)) if64 ();

    imm_decode_stage #(.XLEN(32), .SKID(1)) u32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (if32.slave)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1)) u64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (if64.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] insn, input logic [63:0] pc);
        if32.in_valid = v;
        if32.in_insn  = insn;
        if32.in_pc    = pc[31:0];
        if64.in_valid = v;
        if64.in_insn  = insn;
        if64.in_pc    = pc;
    endtask

    task automatic set_ordy(input logic r);
        if32.out_ready = r;
        if64.out_ready = r;
    endtask

    task automatic send(input logic [31:0] insn, input logic [63:0] pc);
        drive(1'b1, insn, pc);
        tick();
        drive(1'b0, 32'h0, 64'h0);
    endtask

    task automatic chk32(input string tag, input logic [31:0] imm, input logic [31:0] jimm,
                         input logic [31:0] tgt, input logic [2:0] fmt, input logic ill);
        chk({tag, ".vld32"}, 64'(if32.out_valid), 64'd1);
        chk({tag, ".imm32"}, 64'(if32.out_imm), 64'(imm));
        chk({tag, ".jimm32"}, 64'(if32.out_jimm), 64'(jimm));
        chk({tag, ".tgt32"}, 64'(if32.out_target), 64'(tgt));
        chk({tag, ".fmt32"}, 64'(if32.out_fmt), 64'(fmt));
        chk({tag, ".ill32"}, 64'(if32.out_illegal), 64'(ill));
    endtask

    task automatic chk64(input string tag, input logic [63:0] imm, input logic [63:0] jimm,
                         input logic [63:0] tgt, input logic [2:0] fmt, input logic ill);
        chk({tag, ".vld64"}, 64'(if64.out_valid), 64'd1);
        chk({tag, ".imm64"}, if64.out_imm, imm);
        chk({tag, ".jimm64"}, if64.out_jimm, jimm);
        chk({tag, ".tgt64"}, if64.out_target, tgt);
        chk({tag, ".fmt64"}, 64'(if64.out_fmt), 64'(fmt));
        chk({tag, ".ill64"}, 64'(if64.out_illegal), 64'(ill));
    endtask

    initial begin
        drive(1'b0, 32'h0, 64'h0);
        set_ordy(1'b1);

        // Reset state
        tick();
        tick();
        chk("rst.in_ready32", 64'(if32.in_ready), 64'd0);
        chk("rst.in_ready64", 64'(if64.in_ready), 64'd0);
        chk("rst.out_valid32", 64'(if32.out_valid), 64'd0);
        chk("rst.out_imm32", 64'(if32.out_imm), 64'd0);
        chk("rst.out_insn64", 64'(if64.out_insn), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready32", 64'(if32.in_ready), 64'd1);
        chk("post_rst.in_ready64", 64'(if64.in_ready), 64'd1);

        // ADDI x1,x0,-1
        send(32'hFFF00093, 64'h0);
        chk32("addi", 32'hFFFFFFFF, 32'h0, 32'h0, 3'd1, 1'b0);
        chk64("addi", 64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'h0, 3'd1, 1'b0);
        chk("addi.insn", 64'(if32.out_insn), 64'h00000000_FFF00093);

        // SLLI by 5
        send(32'h00509093, 64'h0);
        chk32("slli5", 32'd5, 32'h0, 32'h0, 3'd1, 1'b0);
        chk64("slli5", 64'd5, 64'h0, 64'h0, 3'd1, 1'b0);

        // SLLI with shamt[5] set: illegal on RV32, shift by 32 on RV64
        send(32'h02009093, 64'h0);
        chk32("slli32", 32'h0, 32'h0, 32'h0, 3'd0, 1'b1);
        chk64("slli32", 64'd32, 64'h0, 64'h0, 3'd1, 1'b0);

        // JAL +8 from 0x100
        send(32'h0080006F, 64'h100);
        chk32("jal", 32'd4, 32'd8, 32'h108, 3'd5, 1'b0);
        chk64("jal", 64'd4, 64'd8, 64'h108, 3'd5, 1'b0);
        chk("jal.pc", 64'(if32.out_pc), 64'h100);

        // BEQ -4 from 0x100
        send(32'hFE000EE3, 64'h100);
        chk32("beq", 32'h0, 32'hFFFFFFFC, 32'hFC, 3'd3, 1'b0);
        chk64("beq", 64'h0, 64'hFFFFFFFF_FFFFFFFC, 64'hFC, 3'd3, 1'b0);

        // LUI positive and negative
        send(32'h12345037, 64'h0);
        chk32("lui_pos", 32'h12345000, 32'h0, 32'h0, 3'd4, 1'b0);
        chk64("lui_pos", 64'h00000000_12345000, 64'h0, 64'h0, 3'd4, 1'b0);
        send(32'h80000037, 64'h0);
        chk32("lui_neg", 32'h80000000, 32'h0, 32'h0, 3'd4, 1'b0);
        chk64("lui_neg", 64'hFFFFFFFF_80000000, 64'h0, 64'h0, 3'd4, 1'b0);

        // SW x1,-4(x2)
        send(32'hFE112E23, 64'h0);
        chk32("sw", 32'hFFFFFFFC, 32'h0, 32'h0, 3'd2, 1'b0);
        chk64("sw", 64'hFFFFFFFF_FFFFFFFC, 64'h0, 64'h0, 3'd2, 1'b0);

        // ADDIW x1,x1,1: RV64 only
        send(32'h0010809B, 64'h0);
        chk32("addiw", 32'h0, 32'h0, 32'h0, 3'd0, 1'b1);
        chk64("addiw", 64'd1, 64'h0, 64'h0, 3'd1, 1'b0);

        // Unknown opcode 0x7F and compressed-looking encoding
        send(32'h0000007F, 64'h0);
        chk32("op7f", 32'h0, 32'h0, 32'h0, 3'd0, 1'b1);
        chk64("op7f", 64'h0, 64'h0, 64'h0, 3'd0, 1'b1);
        send(32'hFFF00090, 64'h0);
        chk32("lowbits", 32'h0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Drain, then fill both entries while stalled
        tick();
        chk("drain.out_valid", 64'(if32.out_valid), 64'd0);
        set_ordy(1'b0);
        drive(1'b1, 32'h00100093, 64'h10);
        tick();
        drive(1'b1, 32'h00200093, 64'h14);
        tick();
        drive(1'b1, 32'h00300093, 64'h18);
        chk("skid.in_ready", 64'(if32.in_ready), 64'd0);
        chk("skid.in_ready64", 64'(if64.in_ready), 64'd0);
        chk("skid.out_insn_a", 64'(if32.out_insn), 64'h00100093);
        tick();
        chk("skid.hold_insn_a", 64'(if32.out_insn), 64'h00100093);
        chk("skid.hold_valid", 64'(if32.out_valid), 64'd1);
        chk("skid.hold_rdy", 64'(if32.in_ready), 64'd0);
        set_ordy(1'b1);
        tick();
        chk("skid.out_insn_b", 64'(if32.out_insn), 64'h00200093);
        chk("skid.out_imm_b", 64'(if32.out_imm), 64'd2);
        chk("skid.out_pc_b", 64'(if32.out_pc), 64'h14);
        chk("skid.rdy_after", 64'(if32.in_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        chk("skid.out_insn_c", 64'(if32.out_insn), 64'h00300093);
        chk("skid.out_imm_c64", if64.out_imm, 64'd3);
        chk("skid.out_valid_c", 64'(if32.out_valid), 64'd1);
        tick();
        chk("skid.empty", 64'(if32.out_valid), 64'd0);

        // Flush with two held entries and a new offer
        set_ordy(1'b0);
        drive(1'b1, 32'h00400093, 64'h20);
        tick();
        drive(1'b1, 32'h00500093, 64'h24);
        tick();
        drive(1'b1, 32'h00600093, 64'h28);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        chk("flush.out_valid", 64'(if32.out_valid), 64'd0);
        chk("flush.out_valid64", 64'(if64.out_valid), 64'd0);
        chk("flush.in_ready", 64'(if32.in_ready), 64'd1);
        set_ordy(1'b1);
        tick();
        chk("flush.no_emit", 64'(if32.out_valid), 64'd0);

        // Reset in the middle of a stall
        set_ordy(1'b0);
        drive(1'b1, 32'h00700093, 64'h30);
        tick();
        drive(1'b1, 32'h00800093, 64'h34);
        tick();
        drive(1'b1, 32'h00900093, 64'h38);
        rst = 1'b1;
        tick();
        drive(1'b0, 32'h0, 64'h0);
        chk("mrst.out_valid", 64'(if32.out_valid), 64'd0);
        chk("mrst.out_insn", 64'(if32.out_insn), 64'd0);
        chk("mrst.out_imm64", if64.out_imm, 64'd0);
        chk("mrst.out_pc", 64'(if32.out_pc), 64'd0);
        chk("mrst.in_ready", 64'(if32.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("mrst.in_ready_after", 64'(if32.in_ready), 64'd1);
        set_ordy(1'b1);
        tick();
        chk("mrst.no_emit", 64'(if32.out_valid), 64'd0);
        chk("mrst.no_emit64", 64'(if64.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
